// File: rtl/omp_iter_ctrl.sv
// OMP iteration sequencer: drives atom selection and residual update per
// iteration, records selected atoms and reports duplicate/timeout errors.
module omp_iter_ctrl #(
    parameter int          K_MAX   = 16,
    parameter int          TO_W    = 16,
    parameter int unsigned TIMEOUT = 16'hFFFF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 mode,
    input  logic [4:0]           k_target,
    output logic [5:0]           N,
    output logic [2:0]           M,
    output logic                 start_a,
    output logic [4:0]           current_i,
    output logic [7*K_MAX-1:0]   lambda_history,
    input  logic [5:0]           lambda,
    input  logic                 block_a_done,
    output logic                 start_b,
    input  logic                 block_b_done,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           err,
    output logic [4:0]           iter_count
);

    localparam int IW = (K_MAX > 1) ? $clog2(K_MAX) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CFG,
        S_START_A,
        S_WAIT_A,
        S_COMMIT,
        S_START_B,
        S_WAIT_B,
        S_NEXT,
        S_FIN
    } state_t;

    state_t                   state_q, state_d;
    logic                     mode_q, mode_d;
    logic [4:0]               k_q, k_d;
    logic [5:0]               n_q, n_d;
    logic [2:0]               m_q, m_d;
    logic [4:0]               cur_i_q, cur_i_d;
    logic [4:0]               iter_q, iter_d;
    logic [1:0]               err_q, err_d;
    logic [TO_W-1:0]          wd_q, wd_d;
    logic [5:0]               lam_q, lam_d;
    logic [K_MAX-1:0][6:0]    hist_q, hist_d;

    logic       dup;
    logic       wd_hit;
    logic [4:0] k_clamp;

    assign k_clamp = (k_target > 5'(K_MAX)) ? 5'(K_MAX) : k_target;
    assign wd_hit  = (TIMEOUT != 0) && (wd_q == TO_LAST);

    always_comb begin
        dup = 1'b0;
        for (int j = 0; j < K_MAX; j++) begin
            if (hist_q[j][6] && (hist_q[j][5:0] == lam_q)) begin
                dup = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        k_d     = k_q;
        n_d     = n_q;
        m_d     = m_q;
        cur_i_d = cur_i_q;
        iter_d  = iter_q;
        err_d   = err_q;
        wd_d    = wd_q;
        lam_d   = lam_q;
        hist_d  = hist_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    k_d     = k_clamp;
                    state_d = S_CFG;
                end
            end
            S_CFG: begin
                n_d     = mode_q ? 6'd63 : 6'd15;
                m_d     = mode_q ? 3'd7 : 3'd1;
                hist_d  = '0;
                cur_i_d = '0;
                iter_d  = '0;
                err_d   = 2'b00;
                wd_d    = '0;
                state_d = (k_q == 5'd0) ? S_FIN : S_START_A;
            end
            S_START_A: begin
                wd_d    = '0;
                state_d = S_WAIT_A;
            end
            S_WAIT_A: begin
                if (block_a_done) begin
                    lam_d   = lambda;
                    wd_d    = '0;
                    state_d = S_COMMIT;
                end else if (wd_hit) begin
                    err_d   = 2'b10;
                    state_d = S_FIN;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_COMMIT: begin
                if (dup) begin
                    err_d   = 2'b01;
                    state_d = S_FIN;
                end else begin
                    if (cur_i_q < 5'(K_MAX)) begin
                        hist_d[cur_i_q[IW-1:0]] = {1'b1, lam_q};
                    end
                    iter_d  = iter_q + 5'd1;
                    state_d = S_START_B;
                end
            end
            S_START_B: begin
                wd_d    = '0;
                state_d = S_WAIT_B;
            end
            S_WAIT_B: begin
                if (block_b_done) begin
                    wd_d    = '0;
                    state_d = S_NEXT;
                end else if (wd_hit) begin
                    err_d   = 2'b10;
                    state_d = S_FIN;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_NEXT: begin
                // Second term keeps the index inside the history window.
                if ((cur_i_q + 5'd1) == k_q ||
                    cur_i_q == 5'(K_MAX - 1)) begin
                    state_d = S_FIN;
                end else begin
                    cur_i_d = cur_i_q + 5'd1;
                    state_d = S_START_A;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            k_q     <= '0;
            n_q     <= '0;
            m_q     <= '0;
            cur_i_q <= '0;
            iter_q  <= '0;
            err_q   <= 2'b00;
            wd_q    <= '0;
            lam_q   <= '0;
            hist_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            k_q     <= k_d;
            n_q     <= n_d;
            m_q     <= m_d;
            cur_i_q <= cur_i_d;
            iter_q  <= iter_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
            lam_q   <= lam_d;
            hist_q  <= hist_d;
        end
    end

    assign N              = n_q;
    assign M              = m_q;
    assign current_i      = cur_i_q;
    assign iter_count     = iter_q;
    assign err            = err_q;
    assign lambda_history = hist_q;
    assign start_a        = (state_q == S_START_A);
    assign start_b        = (state_q == S_START_B);
    assign done           = (state_q == S_FIN);
    assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_omp_iter_ctrl.sv
// Directed bench for omp_iter_ctrl with 1-cycle selection/update responders.
module tb_omp_iter_ctrl;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         mode;
    logic [4:0]   k_target;
    logic [5:0]   N;
    logic [2:0]   M;
    logic         start_a;
    logic [4:0]   current_i;
    logic [111:0] lambda_history;
    logic [5:0]   lambda;
    logic         block_a_done;
    logic         start_b;
    logic         block_b_done;
    logic         busy;
    logic         done;
    logic [1:0]   err;
    logic [4:0]   iter_count;

    int checks;
    int failures;
    logic [5:0] lam_tab [16];

    omp_iter_ctrl #(
        .K_MAX  (16),
        .TO_W   (16),
        .TIMEOUT(8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .mode          (mode),
        .k_target      (k_target),
        .N             (N),
        .M             (M),
        .start_a       (start_a),
        .current_i     (current_i),
        .lambda_history(lambda_history),
        .lambda        (lambda),
        .block_a_done  (block_a_done),
        .start_b       (start_b),
        .block_b_done  (block_b_done),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .iter_count    (iter_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts a solve and plays both responders; cycle 1 is the CFG cycle.
    task automatic run_solve(
        input  logic       md,
        input  logic [4:0] kt,
        input  int         lim,
        input  int         xs,
        input  bit         inj,
        input  bit         b_en,
        output int         dc,
        output int         na,
        output int         nb,
        output int         maxi
    );
        bit a_pend;
        bit b_pend;
        int idx;
        a_pend = 1'b0;
        b_pend = 1'b0;
        idx    = 0;
        dc     = 0;
        na     = 0;
        nb     = 0;
        maxi   = 0;
        @(negedge clk);
        start    = 1'b1;
        mode     = md;
        k_target = kt;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= lim; n++) begin
            if (start_a) na++;
            if (start_b) nb++;
            if (int'(current_i) > maxi) maxi = int'(current_i);
            if (done) dc = n;
            block_a_done = a_pend | (inj & b_pend);
            block_b_done = b_pend;
            if (a_pend && idx < 16) begin
                lambda = lam_tab[idx];
                idx++;
            end
            a_pend = start_a;
            b_pend = start_b & b_en;
            start  = (n == xs);
            if (n == xs) begin
                mode     = ~md;
                k_target = 5'd1;
            end
            if (done) break;
            if (n < lim) @(negedge clk);
        end
        block_a_done = 1'b0;
        block_b_done = 1'b0;
        start        = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (N !== 6'd0 || M !== 3'd0) begin
            failures++;
            $display("FAIL reset_nm got N=%0d M=%0d exp 0 0", N, M);
        end
        checks++;
        if (lambda_history !== '0 || current_i !== 5'd0) begin
            failures++;
            $display("FAIL reset_hist got hist=%h ci=%0d exp 0", lambda_history, current_i);
        end
        checks++;
        if ({busy, done, start_a, start_b, err, iter_count} !== 11'd0) begin
            failures++;
            $display("FAIL reset_ctrl got busy=%b done=%b sa=%b sb=%b err=%b it=%0d exp all 0",
                     busy, done, start_a, start_b, err, iter_count);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int dc, na, nb, mx;
        logic [111:0] exp_h;
        lam_tab[0] = 6'd5;
        lam_tab[1] = 6'd9;
        lam_tab[2] = 6'd2;
        run_solve(1'b0, 5'd3, 200, 0, 1'b0, 1'b1, dc, na, nb, mx);
        exp_h = '0;
        exp_h[6:0]   = 7'h45;
        exp_h[13:7]  = 7'h49;
        exp_h[20:14] = 7'h42;
        checks++;
        if (dc !== 20) begin
            failures++;
            $display("FAIL basic_done_cycle got=%0d exp=20", dc);
        end
        checks++;
        if (na !== 3 || nb !== 3) begin
            failures++;
            $display("FAIL basic_pulses got a=%0d b=%0d exp 3 3", na, nb);
        end
        @(negedge clk);
        checks++;
        if (N !== 6'd15 || M !== 3'd1) begin
            failures++;
            $display("FAIL basic_nm got N=%0d M=%0d exp 15 1", N, M);
        end
        checks++;
        if (lambda_history !== exp_h) begin
            failures++;
            $display("FAIL basic_hist got=%h exp=%h", lambda_history, exp_h);
        end
        checks++;
        if (err !== 2'b00 || iter_count !== 5'd3) begin
            failures++;
            $display("FAIL basic_status got err=%b it=%0d exp 00 3", err, iter_count);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL basic_idle got busy=%b done=%b exp 0 0", busy, done);
        end
    endtask

    task automatic test_clamp();
        int dc, na, nb, mx;
        logic [111:0] exp_h;
        exp_h = '0;
        for (int j = 0; j < 16; j++) begin
            lam_tab[j] = 6'(j + 10);
            exp_h[7*j +: 7] = {1'b1, 6'(j + 10)};
        end
        run_solve(1'b1, 5'd20, 300, 0, 1'b0, 1'b1, dc, na, nb, mx);
        checks++;
        if (dc !== 98) begin
            failures++;
            $display("FAIL clamp_done_cycle got=%0d exp=98", dc);
        end
        checks++;
        if (na !== 16 || nb !== 16 || mx !== 15) begin
            failures++;
            $display("FAIL clamp_iters got a=%0d b=%0d maxi=%0d exp 16 16 15", na, nb, mx);
        end
        @(negedge clk);
        checks++;
        if (N !== 6'd63 || M !== 3'd7) begin
            failures++;
            $display("FAIL clamp_nm got N=%0d M=%0d exp 63 7", N, M);
        end
        checks++;
        if (lambda_history !== exp_h || iter_count !== 5'd16) begin
            failures++;
            $display("FAIL clamp_hist got=%h it=%0d exp=%h 16", lambda_history, iter_count, exp_h);
        end
    endtask

    task automatic test_k_zero();
        int dc, na, nb, mx;
        run_solve(1'b0, 5'd0, 50, 0, 1'b0, 1'b1, dc, na, nb, mx);
        checks++;
        if (dc !== 2 || na !== 0 || nb !== 0) begin
            failures++;
            $display("FAIL k0_timing got done=%0d a=%0d b=%0d exp 2 0 0", dc, na, nb);
        end
        @(negedge clk);
        checks++;
        if (lambda_history !== '0 || iter_count !== 5'd0 || err !== 2'b00) begin
            failures++;
            $display("FAIL k0_state got hist=%h it=%0d err=%b exp 0 0 00",
                     lambda_history, iter_count, err);
        end
    endtask

    task automatic test_duplicate();
        int dc, na, nb, mx;
        logic [111:0] exp_h;
        lam_tab[0] = 6'd7;
        lam_tab[1] = 6'd7;
        exp_h = '0;
        exp_h[6:0] = 7'h47;
        run_solve(1'b0, 5'd4, 200, 0, 1'b0, 1'b1, dc, na, nb, mx);
        checks++;
        if (dc !== 11 || na !== 2 || nb !== 1) begin
            failures++;
            $display("FAIL dup_timing got done=%0d a=%0d b=%0d exp 11 2 1", dc, na, nb);
        end
        @(negedge clk);
        checks++;
        if (err !== 2'b01 || iter_count !== 5'd1) begin
            failures++;
            $display("FAIL dup_status got err=%b it=%0d exp 01 1", err, iter_count);
        end
        checks++;
        if (lambda_history !== exp_h) begin
            failures++;
            $display("FAIL dup_hist got=%h exp=%h", lambda_history, exp_h);
        end
    endtask

    task automatic test_timeout();
        int dc, na, nb, mx;
        lam_tab[0] = 6'd33;
        run_solve(1'b0, 5'd2, 200, 0, 1'b0, 1'b0, dc, na, nb, mx);
        checks++;
        if (dc !== 14 || na !== 1 || nb !== 1) begin
            failures++;
            $display("FAIL to_timing got done=%0d a=%0d b=%0d exp 14 1 1", dc, na, nb);
        end
        @(negedge clk);
        checks++;
        if (err !== 2'b10 || iter_count !== 5'd1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL to_status got err=%b it=%0d busy=%b exp 10 1 0", err, iter_count, busy);
        end
    endtask

    task automatic test_ignored_pulses();
        int dc, na, nb, mx;
        logic [111:0] exp_h;
        lam_tab[0] = 6'd3;
        lam_tab[1] = 6'd4;
        exp_h = '0;
        exp_h[6:0]  = 7'h43;
        exp_h[13:7] = 7'h44;
        run_solve(1'b0, 5'd2, 200, 3, 1'b1, 1'b1, dc, na, nb, mx);
        checks++;
        if (dc !== 14 || na !== 2 || nb !== 2) begin
            failures++;
            $display("FAIL ign_timing got done=%0d a=%0d b=%0d exp 14 2 2", dc, na, nb);
        end
        @(negedge clk);
        checks++;
        if (N !== 6'd15 || iter_count !== 5'd2 || err !== 2'b00 || lambda_history !== exp_h) begin
            failures++;
            $display("FAIL ign_state got N=%0d it=%0d err=%b hist=%h exp 15 2 00 %h",
                     N, iter_count, err, lambda_history, exp_h);
        end
    endtask

    task automatic test_back_to_back();
        int dc, na, nb, mx;
        logic [111:0] exp_h;
        lam_tab[0] = 6'd5;
        lam_tab[1] = 6'd9;
        lam_tab[2] = 6'd2;
        run_solve(1'b1, 5'd3, 8, 0, 1'b0, 1'b1, dc, na, nb, mx);
        checks++;
        if (na !== 2 || iter_count !== 5'd1) begin
            failures++;
            $display("FAIL abort_pre got a=%0d it=%0d exp 2 1", na, iter_count);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (lambda_history !== '0 || iter_count !== 5'd0 || current_i !== 5'd0) begin
            failures++;
            $display("FAIL abort_clear got hist=%h it=%0d ci=%0d exp 0 0 0",
                     lambda_history, iter_count, current_i);
        end
        checks++;
        if (N !== 6'd0 || M !== 3'd0 || busy !== 1'b0 || err !== 2'b00) begin
            failures++;
            $display("FAIL abort_ctrl got N=%0d M=%0d busy=%b err=%b exp 0 0 0 00", N, M, busy, err);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_h = '0;
        exp_h[6:0]  = 7'h45;
        exp_h[13:7] = 7'h49;
        run_solve(1'b0, 5'd2, 200, 0, 1'b0, 1'b1, dc, na, nb, mx);
        checks++;
        if (dc !== 14 || na !== 2 || nb !== 2) begin
            failures++;
            $display("FAIL fresh_timing got done=%0d a=%0d b=%0d exp 14 2 2", dc, na, nb);
        end
        @(negedge clk);
        checks++;
        if (lambda_history !== exp_h || err !== 2'b00 || iter_count !== 5'd2) begin
            failures++;
            $display("FAIL fresh_state got hist=%h err=%b it=%0d exp %h 00 2",
                     lambda_history, err, iter_count, exp_h);
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        start        = 1'b0;
        mode         = 1'b0;
        k_target     = 5'd0;
        lambda       = 6'd0;
        block_a_done = 1'b0;
        block_b_done = 1'b0;
        rst_n        = 1'b1;
        test_reset();
        test_basic();
        test_clamp();
        test_k_zero();
        test_duplicate();
        test_timeout();
        test_ignored_pulses();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/omp_iter_ctrl.md
Name: omp_iter_ctrl

Overview:
Iteration sequencer for the OMP core. Configures the atom-selection block (N/M geometry, iteration index, selected-atom history), pulses it once per iteration, captures the returned lambda into the history, then hands off to the residual/least-squares update block. It repeats this until K atoms are chosen or an error occurs. Sits between the host control interface and the atom-selection / residual-update datapaths.

Parameters:
K_MAX, 16, maximum iterations; history holds K_MAX entries
TO_W, 16, width of the per-phase watchdog counter
TIMEOUT, 16'hFFFF, max cycles allowed waiting on either done; 0 disables

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to run a full OMP solve
mode  in  1  0: N=15, M=1 (16 atoms, 2 BRAM rows); 1: N=63, M=7
k_target  in  5  requested sparsity; 0 = no iterations; >K_MAX clamped to K_MAX
N  out  6  atom column limit to selection block
M  out  3  BRAM row limit to selection block
start_a  out  1  one-cycle pulse starting atom selection
current_i  out  5  current iteration index
lambda_history  out  112  16 entries x 7 bits; entry j = bits[7j+6:7j] = {valid, lambda[5:0]}
lambda  in  6  selected atom index
block_a_done  in  1  selection-complete pulse
start_b  out  1  one-cycle pulse starting residual update
block_b_done  in  1  residual-update-complete pulse
busy  out  1  high from the cycle after accepted start until the DONE state is left
done  out  1  one-cycle pulse at end of a solve
err  out  2  00 ok, 01 duplicate lambda, 10 timeout; held until next accepted start
iter_count  out  5  atoms successfully committed in last or current solve

Behaviour:
- Reset (async, rst_n low): state IDLE. All outputs 0, including N, M, current_i, lambda_history, err and iter_count.
- States: IDLE, CFG, START_A, WAIT_A, COMMIT, START_B, WAIT_B, NEXT, FIN.
- IDLE: start=1 moves to CFG. Latch mode and K = min(k_target, K_MAX). start is ignored in every other state.
- CFG (1 cycle): drive N/M from mode. Clear lambda_history, current_i, iter_count, err and the watchdog. If K==0, go to FIN; otherwise go to START_A.
- START_A: start_a=1 for exactly this cycle, then WAIT_A. N, M, current_i and lambda_history stay stable from CFG until FIN.
- WAIT_A: watchdog increments each cycle. block_a_done moves to COMMIT and clears the watchdog. Watchdog reaching TIMEOUT (nonzero) sets err=10 and goes to FIN.
- COMMIT (1 cycle): compare lambda against all valid history entries.
  - Match: err=01, go to FIN, history unchanged.
  - No match: write entry[current_i]={1,lambda}, iter_count+1, go to START_B.
- START_B: start_b=1 for one cycle, then WAIT_B.
- WAIT_B: same watchdog rule as WAIT_A, with block_b_done as the exit condition.
- NEXT (1 cycle): if current_i+1==K go to FIN; otherwise current_i+1, go to START_A.
- FIN: done=1 for one cycle, go to IDLE. N, M, history, iter_count and err hold until the next CFG.
- Latency for one iteration with 1-cycle done responders: START_A→WAIT_A→COMMIT→START_B→WAIT_B→NEXT = 6 cycles. A solve with K=k is 2 + 6k cycles from start to done, inclusive of CFG and FIN.
- Done inputs arriving outside their wait state are ignored. block_a_done and block_b_done in the same cycle: only the one matching the current state acts.
- current_i never exceeds K_MAX-1. No history write beyond entry K_MAX-1.
- rst_n asserted mid-solve aborts immediately to reset values. The next solve must not reuse stale history.

Test Plan:
- Reset then start, mode=0, k_target=3, responders return lambdas 5, 9, 2 with 1-cycle done: start_a/start_b pulse 3 times each; N=15, M=1; history low 21 bits = {1,2},{1,9},{1,5}; done at cycle 20; err=00; iter_count=3.
- mode=1, k_target=20: clamps to 16 iterations, N=63, M=7; all 16 entries valid; current_i peaks at 15.
- k_target=0: done 2 cycles after start; no start_a; history all 0.
- Lambdas 7, 7: second COMMIT sets err=01; done asserted; iter_count=1; only 1 start_b pulse.
- TIMEOUT=8 with block_b_done never asserted: err=10 after 8 WAIT_B cycles; done pulse; busy drops.
- Pulse start while busy, pulse block_a_done during WAIT_B, assert rst_n low in WAIT_A: extra pulses ignored; reset clears all outputs; a fresh solve runs correctly.
